// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: three-requester round-robin arbiter that grants a shared
// register-file write port for bursts of up to MAX_HOLD beats. A one-cycle
// GAP separates consecutive grants. A grant revoked by the hold limit
// (rather than by the owner's last flag) is reported with a one-cycle pulse.
module reg_bus_arbiter #(
    parameter int MAX_HOLD = 4  // maximum write beats per grant, 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  last,
    input  logic [11:0] addr_in,
    input  logic [23:0] data_in,
    output logic [2:0]  grant,
    output logic        cfg_we,
    output logic [3:0]  cfg_addr,
    output logic [7:0]  cfg_data,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // The beat counter is 4 bits wide, so the limit must fit in 1..15.
    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t      state;
    logic [1:0]  ptr;          // requester searched first at the next arbitration
    logic [3:0]  beat_cnt;     // beats written in the current grant

    logic        owner_req;
    logic        owner_last;
    logic        win_valid;
    logic [1:0]  win_idx;
    logic [3:0]  beat_cnt_inc;
    logic        hold_hit;

    // Adds two requester indices modulo 3 (inputs are always below 6).
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Owner mux: the registered one-hot grant selects which requester's
    // req/last/addr/data reach the shared port; everything is zero when idle.
    // Because grant is a register cleared asynchronously, reset removes
    // cfg_we immediately without waiting for a clock edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        owner_req  = 1'b0;
        owner_last = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        case (grant)
            3'b001: begin
                owner_req  = req[0];
                owner_last = last[0];
                cfg_addr   = addr_in[3:0];
                cfg_data   = data_in[7:0];
            end
            3'b010: begin
                owner_req  = req[1];
                owner_last = last[1];
                cfg_addr   = addr_in[7:4];
                cfg_data   = data_in[15:8];
            end
            3'b100: begin
                owner_req  = req[2];
                owner_last = last[2];
                cfg_addr   = addr_in[11:8];
                cfg_data   = data_in[23:16];
            end
            default: ;
        endcase
    end

    assign cfg_we = owner_req;
    assign busy   = (state == ST_GRANT);

    // Round-robin search: ptr first, then ptr+1, ptr+2 (mod 3). Scanning from
    // the lowest priority upward lets the highest-priority hit overwrite.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (req[wrap3({1'b0, ptr} + 3'(k))]) begin
                win_valid = 1'b1;
                win_idx   = wrap3({1'b0, ptr} + 3'(k));
            end
        end
    end

    // Saturating next beat count and hold-limit detection for the current beat.
    always_comb begin
        beat_cnt_inc = (beat_cnt == 4'hF) ? beat_cnt : beat_cnt + 4'd1;
        hold_hit     = (beat_cnt_inc == HOLD_LIMIT);
    end

    // Arbiter FSM with registered grant, pointer, beat counter and timeout.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            ptr      <= 2'd0;
            beat_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            // timeout is only ever set on the GRANT->GAP transition, so it
            // lasts exactly one cycle.
            timeout <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (win_valid) begin
                        state    <= ST_GRANT;
                        grant    <= 3'b001 << win_idx;
                        ptr      <= wrap3({1'b0, win_idx} + 3'd1);
                        beat_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end
                end
                ST_GRANT: begin
                    if (owner_req) begin
                        beat_cnt <= beat_cnt_inc;
                        if (owner_last || hold_hit) begin
                            state   <= ST_GAP;
                            grant   <= '0;
                            timeout <= hold_hit && !owner_last;
                        end
                    end else begin
                        // Owner withdrew its request: release without a beat.
                        state <= ST_GAP;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed testbench for reg_bus_arbiter (MAX_HOLD = 4). Inputs change 1 ns
// after each rising edge; outputs are sampled 3 ns after the edge.
module tb_reg_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  last;
    logic [11:0] addr_in;
    logic [23:0] data_in;
    logic [2:0]  grant;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        busy;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .last     (last),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .grant    (grant),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the whole output set at the current sample point.
    task automatic check_all(input string tag, input logic [2:0] e_grant, input logic e_we,
                             input logic [3:0] e_addr, input logic [7:0] e_data,
                             input logic e_busy, input logic e_timeout);
        check({tag, ".grant"},   32'(grant),    32'(e_grant));
        check({tag, ".cfg_we"},  32'(cfg_we),   32'(e_we));
        check({tag, ".addr"},    32'(cfg_addr), 32'(e_addr));
        check({tag, ".data"},    32'(cfg_data), 32'(e_data));
        check({tag, ".busy"},    32'(busy),     32'(e_busy));
        check({tag, ".timeout"}, 32'(timeout),  32'(e_timeout));
    endtask

    initial begin
        logic [2:0] rr_grant [7];
        logic [3:0] rr_addr  [7];

        rst = 1'b1; req = '0; last = '0; addr_in = '0; data_in = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        #2 check_all("reset", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // ---------------- round robin, req=111, last on every beat ----------------
        req = 3'b111; last = 3'b111;
        addr_in = 12'h321; data_in = 24'hC2_B1_A0;
        #2 check_all("rr.idle", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();
        rr_grant = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        rr_addr  = '{4'h1,   4'h0,   4'h2,   4'h0,   4'h3,   4'h0,   4'h1};
        for (int i = 0; i < 7; i++) begin
            #2;
            check($sformatf("rr.grant%0d", i), 32'(grant), 32'(rr_grant[i]));
            check($sformatf("rr.we%0d", i), 32'(cfg_we), 32'(rr_grant[i] != 3'b000));
            check($sformatf("rr.addr%0d", i), 32'(cfg_addr), 32'(rr_addr[i]));
            check($sformatf("rr.busy%0d", i), 32'(busy), 32'(rr_grant[i] != 3'b000));
            tick();
        end
        // now in GAP after the final 001 grant; drop everything so GAP -> IDLE
        req = '0; last = '0;
        #2 check_all("rr.gap", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();

        // ---------------- single requester, last on beat 2 ----------------
        req = 3'b001; addr_in = 12'h9A5; data_in = 24'h3C_5E_A7;
        #2 check_all("single.idle", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();
        #2 check_all("single.beat1", 3'b001, 1'b1, 4'h5, 8'hA7, 1'b1, 1'b0);
        tick();
        last = 3'b001;
        #2 check_all("single.beat2", 3'b001, 1'b1, 4'h5, 8'hA7, 1'b1, 1'b0);
        tick();
        req = '0; last = '0;
        #2 check_all("single.gap", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();
        #2 check_all("single.idle2", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);

        // ---------------- timeout: req=010 held, last=0 ----------------
        req = 3'b010; addr_in = 12'h070; data_in = 24'h00_5A_00;
        tick();
        for (int b = 1; b <= 4; b++) begin
            #2 check_all($sformatf("tmo.beat%0d", b), 3'b010, 1'b1, 4'h7, 8'h5A, 1'b1, 1'b0);
            tick();
        end
        #2 check_all("tmo.gap", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        tick();
        #2 check_all("tmo.regrant", 3'b010, 1'b1, 4'h7, 8'h5A, 1'b1, 1'b0);
        req = '0;
        #1 check("tmo.drop_we", 32'(cfg_we), 32'(0));
        tick();
        #2 check_all("tmo.gap2", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();

        // ---------------- owner drops req after one beat ----------------
        req = 3'b001; addr_in = 12'h0B4; data_in = 24'h00_11_22;
        tick();
        #2 check_all("drop.beat1", 3'b001, 1'b1, 4'h4, 8'h22, 1'b1, 1'b0);
        tick();
        // owner 0 withdraws; requester 1 raising meanwhile must not be served
        req = 3'b010;
        #2 check_all("drop.withdraw", 3'b001, 1'b0, 4'h4, 8'h22, 1'b1, 1'b0);
        tick();
        #2 check_all("drop.gap", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();
        // arbitration in GAP hands the port to requester 1 immediately
        #2 check_all("drop.next", 3'b010, 1'b1, 4'hB, 8'h11, 1'b1, 1'b0);
        req = '0;
        tick(); tick();

        // ---------------- last coincides with the MAX_HOLD beat ----------------
        req = 3'b100; last = 3'b011; addr_in = 12'hE00; data_in = 24'h6D_00_00;
        tick();
        for (int b = 1; b <= 3; b++) begin
            #2 check_all($sformatf("coin.beat%0d", b), 3'b100, 1'b1, 4'hE, 8'h6D, 1'b1, 1'b0);
            tick();
        end
        last = 3'b111;
        #2 check_all("coin.beat4", 3'b100, 1'b1, 4'hE, 8'h6D, 1'b1, 1'b0);
        tick();
        req = '0; last = '0;
        #2 check_all("coin.gap", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();

        // ---------------- asynchronous reset mid-grant ----------------
        req = 3'b010; addr_in = 12'h0C0; data_in = 24'h00_99_00;
        tick();
        #2 check_all("arst.beat1", 3'b010, 1'b1, 4'hC, 8'h99, 1'b1, 1'b0);
        tick();
        #2 check_all("arst.beat2", 3'b010, 1'b1, 4'hC, 8'h99, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1 check_all("arst.async", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        req = 3'b110; addr_in = 12'h3C0; data_in = 24'h44_99_00;
        tick();
        rst = 1'b0;
        #2 check_all("arst.released", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();
        // pointer back at 0: requester 0 idle, so requester 1 wins first
        #2 check_all("arst.first", 3'b010, 1'b1, 4'hC, 8'h99, 1'b1, 1'b0);
        req = '0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum write beats per grant (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 3, per-requester write request; bit i belongs to requester i.
REQ-005 The block SHALL have port last, input, 3, per-requester final-beat flag; qualified by req[i].
REQ-006 The block SHALL have port addr_in, input, 12, packed 4-bit register addresses; requester i at bits [4i+3:4i].
REQ-007 The block SHALL have port data_in, input, 24, packed 8-bit write data; requester i at bits [8i+7:8i].
REQ-008 The block SHALL have port grant, output, 3, registered one-hot grant, or all zero.
REQ-009 The block SHALL have port cfg_we, output, 1, shared register-file write enable.
REQ-010 The block SHALL have port cfg_addr, output, 4, shared register-file address.
REQ-011 The block SHALL have port cfg_data, output, 8, shared register-file write data.
REQ-012 The block SHALL have port busy, output, 1, high while in state GRANT.
REQ-013 The block SHALL have port timeout, output, 1, one-cycle pulse when a grant is revoked at MAX_HOLD.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT and GAP, encoded in registers.
REQ-015 IDLE: if any req bit is high, arbitrate, load the one-hot grant and go to GRANT next cycle; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: search starts at requester (ptr), then ptr+1, ptr+2 mod 3; the first high req bit wins.
REQ-017 On entering GRANT, ptr SHALL be set to (winner+1) mod 3.
REQ-018 In GRANT, a beat SHALL be any cycle where req[owner] is high; cfg_we = req[owner] combinationally, gated by grant.
REQ-019 cfg_addr/cfg_data SHALL mux the owner's addr_in/data_in slice; when grant is zero they SHALL be 0.
REQ-020 A 4-bit beat counter SHALL clear on entry to GRANT and increment on every beat.
REQ-021 GRANT SHALL exit to GAP at the clock edge after (a) a beat with last[owner] high, (b) a cycle with req[owner] low, or (c) the beat that makes the count equal MAX_HOLD.
REQ-022 When (c) fires without last[owner], timeout SHALL pulse high for exactly the first GAP cycle; when (a) and (c) coincide, timeout SHALL stay low.
REQ-023 GAP: grant = 0 and cfg_we = 0 for exactly one cycle; arbitration occurs in GAP as in IDLE, giving GRANT next cycle if any req, else IDLE.
REQ-024 Latency: req rising in IDLE at cycle n gives grant and first cfg_we at cycle n+1; after a release edge at T, the next grant is at T+2 at the earliest.
REQ-025 req/last changes of non-owners during GRANT SHALL have no effect until the next arbitration.
REQ-026 The beat counter SHALL saturate and never wrap.

Reset
REQ-027 While rst is high: state IDLE, grant = 0, cfg_we = 0, cfg_addr = 0, cfg_data = 0, busy = 0, timeout = 0, ptr = 0, counter = 0.
REQ-028 Reset asserted mid-GRANT SHALL immediately (asynchronously) drop grant and cfg_we; no partial beat SHALL be written after the edge.
REQ-029 After rst falls, the first arbitration SHALL favour requester 0.

Verification
REQ-030 Single requester: req=001, addr_in[3:0]=5, data_in[7:0]=0xA7, last on beat 2 -> grant=001 one cycle later; two cfg_we pulses at addr 5 with data 0xA7; then GAP; then IDLE.
REQ-031 Round-robin: req=111 held continuously, last on every beat -> grant sequence 001, 010, 100, 001 with one GAP cycle between each.
REQ-032 Timeout: MAX_HOLD=4, req=010 held with last=0 -> exactly 4 cfg_we beats; timeout=1 in the following cycle; re-grant to requester 1 one cycle after that.
REQ-033 Owner drops req mid-burst after 1 beat -> exit to GAP; cfg_we count = 1; timeout stays 0.
REQ-034 Async reset mid-GRANT (beat 2 of 4) -> grant, cfg_we, busy all 0 before the next clock edge; after release with req=110, requester 1 wins first.
REQ-035 last and the MAX_HOLD beat coincide -> release to GAP with timeout = 0.
